// File: rtl/pc_gen_unit_pkg.sv
// Shared constants and next-PC select encoding for the fetch-stage PC generator.
// Imported by the interface, the increment adder and the top level.
package pc_pkg;

   localparam int          DEF_ADDR_W    = 32;
   localparam int          DEF_INC       = 4;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
   localparam logic [31:0] DEF_TEXT_LO   = 32'h0000_3000;
   localparam logic [31:0] DEF_TEXT_HI   = 32'h0000_4FFC;

   typedef enum logic [2:0] {
      SEL_EXC,
      SEL_ERET,
      SEL_HOLD,
      SEL_REDIR,
      SEL_PEND,
      SEL_SEQ
   } next_sel_e;

   // Strict priority: commit-stage events beat the hazard stall, which beats redirects.
   function automatic next_sel_e pick_next_sel(
      input logic exc,
      input logic eret,
      input logic stall,
      input logic redirect,
      input logic pend
   );
      next_sel_e sel;
      if (exc)
         sel = SEL_EXC;
      else if (eret)
         sel = SEL_ERET;
      else if (stall)
         sel = SEL_HOLD;
      else if (redirect)
         sel = SEL_REDIR;
      else if (pend)
         sel = SEL_PEND;
      else
         sel = SEL_SEQ;
      return sel;
   endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Control/status bundle between the pipeline and the PC generator.
// The slave side is the PC generator; the master side drives stall, redirect and commit events.
interface pc_gen_unit_if
   import pc_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              stall_i;
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_tgt_i;
   logic              exc_i;
   logic              eret_i;
   logic [ADDR_W-1:0] epc_i;
   logic [ADDR_W-1:0] pc_o;
   logic [ADDR_W-1:0] pc_inc_o;
   logic              pend_o;
   logic              adel_o;

   modport master (
      output stall_i,
      output redirect_i,
      output redirect_tgt_i,
      output exc_i,
      output eret_i,
      output epc_i,
      input  pc_o,
      input  pc_inc_o,
      input  pend_o,
      input  adel_o
   );

   modport slave (
      input  stall_i,
      input  redirect_i,
      input  redirect_tgt_i,
      input  exc_i,
      input  eret_i,
      input  epc_i,
      output pc_o,
      output pc_inc_o,
      output pend_o,
      output adel_o
   );

endinterface

// File: rtl/pc_gen_unit_incr.sv
// Sequential-fetch adder: pc + INC, modulo 2^ADDR_W (carry out is dropped).
// Also serves as the jal/jalr link value.
module pc_incr
   import pc_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int INC    = DEF_INC
) (
   input  logic [ADDR_W-1:0] pc_i,
   output logic [ADDR_W-1:0] pc_inc_o
);

   assign pc_inc_o = pc_i + ADDR_W'(INC);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC register with prioritised next-PC select, stall-deferred redirects
// and an AdEL (fetch address error) flag for the exception unit.
module pc_gen_unit
   import pc_pkg::*;
#(
   parameter int              ADDR_W    = DEF_ADDR_W,
   parameter int              INC       = DEF_INC,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
   parameter logic [ADDR_W-1:0] TEXT_LO   = ADDR_W'(DEF_TEXT_LO),
   parameter logic [ADDR_W-1:0] TEXT_HI   = ADDR_W'(DEF_TEXT_HI)
) (
   input  logic         clk,
   input  logic         rst_n,
   pc_gen_unit_if.slave bus
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              pend_q;
   logic              pend_d;
   logic [ADDR_W-1:0] pend_tgt_q;
   logic [ADDR_W-1:0] pend_tgt_d;
   logic [ADDR_W-1:0] pc_inc;
   next_sel_e         sel;

   pc_incr #(
      .ADDR_W (ADDR_W),
      .INC    (INC)
   ) u_incr (
      .pc_i     (pc_q),
      .pc_inc_o (pc_inc)
   );

   always_comb begin
      sel        = pick_next_sel(bus.exc_i, bus.eret_i, bus.stall_i,
                                 bus.redirect_i, pend_q);
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      case (sel)
         SEL_EXC: begin
            pc_d   = EXC_VEC;
            pend_d = 1'b0;
         end
         SEL_ERET: begin
            pc_d   = bus.epc_i;
            pend_d = 1'b0;
         end
         SEL_HOLD: begin
            // A newer redirect seen during the stall replaces an older pending one.
            if (bus.redirect_i) begin
               pend_d     = 1'b1;
               pend_tgt_d = bus.redirect_tgt_i;
            end
         end
         SEL_REDIR: begin
            pc_d   = bus.redirect_tgt_i;
            pend_d = 1'b0;
         end
         SEL_PEND: begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
         end
         SEL_SEQ: begin
            pc_d = pc_inc;
         end
         default: begin
            pc_d = pc_inc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VEC;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   // Misaligned or out-of-text targets are loaded as-is; only the flag reports them.
   assign bus.adel_o   = (pc_q[1:0] != 2'b00) | (pc_q < TEXT_LO) | (pc_q > TEXT_HI);
   assign bus.pc_o     = pc_q;
   assign bus.pc_inc_o = pc_inc;
   assign bus.pend_o   = pend_q;

endmodule
